codec_conditioner: RTL and testbench
====================================

Name: codec_conditioner

Overview:
- Downstream stage of the sine sample reader.
- Pulls samples on demand with a one-cycle generate_next request and buffers them in a small FIFO.
- Presents one attenuated sample per codec frame strobe to the audio codec interface.
- Decouples reader latency from codec frame timing, and flags underflow/overflow for debug.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- WIDTH, 16, sample width in bits (two's complement).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  WIDTH  sample from reader.
- sample_ready  input  1  one-cycle strobe: sample_in valid this cycle.
- generate_next  output  1  one-cycle request to reader for the next sample.
- new_frame  input  1  one-cycle strobe from codec: consume one sample.
- atten  input  3  arithmetic right-shift amount applied on output (0 = full scale).
- sample_out  output  WIDTH  registered sample to codec.
- frame_valid  output  1  one-cycle pulse: sample_out was updated from FIFO this cycle.
- underflow  output  1  sticky: new_frame arrived with FIFO empty.
- overflow  output  1  sticky: sample_ready arrived with FIFO full; the sample was dropped.

Behaviour:
- Reset (sync, dominates all other inputs):
  - count=0, rd/wr pointers=0, outstanding=0.
  - sample_out=0, frame_valid=0, generate_next=0, underflow=0, overflow=0.
  - FIFO contents need not be cleared.
- Request logic:
  - generate_next is a registered single-cycle pulse.
  - Asserted in cycle N+1 when, in cycle N: outstanding==0, (count + pushes pending) < DEPTH, and not in reset.
  - The pulse sets outstanding=1.
  - At most one request is in flight. No back-to-back pulses while outstanding.
  - No timeout: the reader always answers.
- Push:
  - On sample_ready: if count<DEPTH, write sample_in at wr_ptr, wr_ptr++ (mod DEPTH), count++.
  - If count==DEPTH: drop the sample and set overflow.
  - sample_ready clears outstanding regardless of whether a request was pending.
  - An unsolicited sample_ready is pushed like any other.
- Pop:
  - On new_frame with count>0 (pre-cycle value): sample_out <= fifo[rd_ptr] >>> atten (sign-extending), rd_ptr++, count--.
  - frame_valid=1 in the following cycle, i.e. aligned with the updated sample_out (latency 1 clock from new_frame).
  - On new_frame with count==0: sample_out holds its previous value, frame_valid stays 0, underflow set.
- Simultaneous push and pop in the same cycle:
  - Both performed; count unchanged.
  - If count==0 before the cycle: pop underflows (no bypass) and the push is stored, count becomes 1.
  - If count==DEPTH before the cycle: pop succeeds and the push is stored (the slot frees in the same cycle), no overflow.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never exceeds DEPTH.
- atten is sampled in the cycle new_frame is accepted; changing it affects only subsequent pops.
- underflow and overflow stay set until reset.
- Steady state: after reset the block fills the FIFO to DEPTH autonomously, issuing one request per reader round trip.

Test Plan:
- Fill after reset:
  - Stimulus: reset 2 cycles, then a reader model answering each generate_next after 3 cycles with samples 0x0001..0x0004; no new_frame.
  - Required: exactly 4 generate_next pulses, each separated by ≥4 cycles; count=4; no 5th request; both flags 0.
- Drain with attenuation:
  - Stimulus: FIFO holds 0x8000, 0x7FFE, 0x0010, 0xFFF0; atten=1; four new_frame pulses.
  - Required: sample_out = 0xC000, 0x3FFF, 0x0008, 0xFFF8, each with a frame_valid pulse 1 cycle after its strobe.
  - Required: refill requests resume after the first pop.
- Underflow:
  - Stimulus: new_frame in the first cycle after reset, before any sample arrives.
  - Required: sample_out stays 0, no frame_valid, underflow=1 and still 1 100 cycles later.
- Simultaneous at full:
  - Stimulus: count=4; unsolicited sample_ready (0x1234) and new_frame in the same cycle.
  - Required: head popped to sample_out, 0x1234 stored at the tail, count=4, overflow=0.
- Overflow:
  - Stimulus: count=4; unsolicited sample_ready alone.
  - Required: sample dropped, overflow=1, count=4; subsequent 4 pops return the original 4 samples in order.
- Reset mid-operation:
  - Stimulus: assert reset while outstanding=1 and count=2; the late sample_ready arrives while reset is still high.
  - Required: everything is 0 after reset; the late sample is not stored; the first generate_next comes in the cycle after reset deasserts.

Source files
------------

// File: rtl/codec_conditioner.sv
// ---------------------------------------------------------------------------
// codec_conditioner: buffers reader samples in a FIFO, one attenuated sample
// per codec frame strobe.                                  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module codec_conditioner #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_ready,
  output logic             generate_next,
  input  logic             new_frame,
  input  logic [2:0]       atten,
  output logic [WIDTH-1:0] sample_out,
  output logic             frame_valid,
  output logic             underflow,
  output logic             overflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_outstanding;
  logic             r_gen;
  logic [WIDTH-1:0] r_sample_out;
  logic             r_frame_valid;
  logic             r_underflow;
  logic             r_overflow;

  logic                    w_pop;
  logic                    w_push;
  logic                    w_req;
  logic [c_cw-1:0]         w_count_next;
  logic signed [WIDTH-1:0] w_head;
  logic signed [WIDTH-1:0] w_shifted;

  // A pop at full frees a slot in the same cycle, so a simultaneous push is kept.
  always_comb begin
    w_pop        = new_frame && (r_count != '0);
    w_push       = sample_ready && ((r_count != c_full) || w_pop);
    w_count_next = r_count + c_cw'(w_push) - c_cw'(w_pop);
    w_req        = !r_outstanding && (w_count_next < c_full);
    w_head       = $signed(r_mem[r_rd_ptr]);
    w_shifted    = w_head >>> atten;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= 1'b0;
      r_gen         <= 1'b0;
      r_sample_out  <= '0;
      r_frame_valid <= 1'b0;
      r_underflow   <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_count       <= w_count_next;
      r_gen         <= w_req;
      r_frame_valid <= w_pop;
      // A new request wins over a same-cycle (unsolicited) reply clearing the flag.
      if (w_req) begin
        r_outstanding <= 1'b1;
      end else if (sample_ready) begin
        r_outstanding <= 1'b0;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= sample_in;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_sample_out <= w_shifted;
        r_rd_ptr     <= r_rd_ptr + c_aw'(1);
      end
      if (new_frame && !w_pop) begin
        r_underflow <= 1'b1;
      end
      if (sample_ready && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign generate_next = r_gen;
  assign sample_out    = r_sample_out;
  assign frame_valid   = r_frame_valid;
  assign underflow     = r_underflow;
  assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_codec_conditioner.sv
// ---------------------------------------------------------------------------
// tb_codec_conditioner: scoreboard bench for codec_conditioner with a
// 3-cycle reader model.                                    Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_codec_conditioner;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_ready;
  logic        generate_next;
  logic        new_frame;
  logic [2:0]  atten;
  logic [15:0] sample_out;
  logic        frame_valid;
  logic        underflow;
  logic        overflow;

  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_en;
  logic        st_ready;
  logic [15:0] st_data;

  logic [15:0] rd_q [$];
  exp_t        exp_q [$];
  int          gen_cycles [$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          p;

  assign sample_ready = rd_ready | st_ready;
  assign sample_in    = st_ready ? st_data : rd_data;

  codec_conditioner #(.DEPTH(4), .WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_ready  (sample_ready),
    .generate_next (generate_next),
    .new_frame     (new_frame),
    .atten         (atten),
    .sample_out    (sample_out),
    .frame_valid   (frame_valid),
    .underflow     (underflow),
    .overflow      (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_frame(input logic [15:0] v);
    exp_t e;
    e.val = v;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    gen_cycles.delete();
  endtask

  // Reader: answers each request 3 cycles later while enabled and data remains.
  initial begin
    rd_ready = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      if (generate_next && rd_en && rd_q.size() > 0) begin
        repeat (3) @(posedge clk);
        #1;
        rd_ready = 1'b1;
        rd_data  = rd_q.pop_front();
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
      end
    end
  end

  // Frame monitor: every frame_valid must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: actual=%0h required=no frame (cycle %0d)", sample_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", {16'h0, sample_out}, {16'h0, e.val});
          check("frame_latency", cyc, e.cyc);
        end
      end
    end
  end

  // Request monitor: pulses must be spaced by at least one reader round trip.
  initial begin
    forever begin
      @(negedge clk);
      if (generate_next) begin
        if (gen_cycles.size() > 0)
          check("gen_gap_ge4", 32'((cyc - gen_cycles[$]) >= 4), 1);
        gen_cycles.push_back(cyc);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    new_frame = 1'b0;
    st_ready  = 1'b0;
    st_data   = '0;
    atten     = '0;
    rd_en     = 1'b0;

    // Underflow straight out of reset
    tick();
    tick();
    reset     = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    check("underflow_set", 32'(underflow), 1);
    check("underflow_out_hold", 32'(sample_out), 0);
    repeat (100) tick();
    check("underflow_sticky", 32'(underflow), 1);
    check("underflow_out_still0", 32'(sample_out), 0);

    // Fill after reset
    rd_q  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    rd_en = 1'b1;
    apply_reset(2);
    check("rst_underflow", 32'(underflow), 0);
    check("rst_sample_out", 32'(sample_out), 0);
    repeat (40) tick();
    check("fill_req_count", gen_cycles.size(), 4);
    check("fill_underflow", 32'(underflow), 0);
    check("fill_overflow", 32'(overflow), 0);

    // Drain at full scale; refill with the attenuation set
    rd_q = '{16'h8000, 16'h7FFE, 16'h0010, 16'hFFF0};
    p = cyc;
    pop_frame(16'h0001);
    pop_frame(16'h0002);
    pop_frame(16'h0003);
    pop_frame(16'h0004);
    repeat (40) tick();
    check("refill_req_count", gen_cycles.size(), 8);
    check("refill_after_first_pop",
          32'((gen_cycles.size() > 4) && (gen_cycles[4] >= p + 1) && (gen_cycles[4] <= p + 2)), 1);

    // Drain with atten=1
    rd_q  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    atten = 3'd1;
    pop_frame(16'hC000);
    pop_frame(16'h3FFF);
    pop_frame(16'h0008);
    pop_frame(16'hFFF8);
    atten = 3'd0;
    repeat (40) tick();
    check("refill2_req_count", gen_cycles.size(), 12);

    // Simultaneous push and pop at full
    st_ready = 1'b1;
    st_data  = 16'h1234;
    pop_frame(16'h1111);
    st_ready = 1'b0;
    repeat (3) tick();
    check("simul_no_overflow", 32'(overflow), 0);
    check("simul_no_request", gen_cycles.size(), 12);

    // Overflow: unsolicited sample while full
    rd_en    = 1'b0;
    st_ready = 1'b1;
    st_data  = 16'h9999;
    tick();
    st_ready = 1'b0;
    tick();
    check("overflow_set", 32'(overflow), 1);
    pop_frame(16'h2222);
    pop_frame(16'h3333);
    pop_frame(16'h4444);
    pop_frame(16'h1234);
    repeat (5) tick();
    check("ovf_drain_no_underflow", 32'(underflow), 0);
    check("overflow_sticky", 32'(overflow), 1);

    // Reset mid-operation: two samples held, one request unanswered
    st_ready = 1'b1;
    st_data  = 16'h0101;
    tick();
    st_ready = 1'b0;
    repeat (3) tick();
    st_ready = 1'b1;
    st_data  = 16'h0202;
    tick();
    st_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    st_ready = 1'b1;
    st_data  = 16'h5555;
    tick();
    st_ready = 1'b0;
    tick();
    rd_q  = '{16'h0AAA};
    rd_en = 1'b1;
    reset = 1'b0;
    gen_cycles.delete();
    check("mid_rst_sample_out", 32'(sample_out), 0);
    check("mid_rst_frame_valid", 32'(frame_valid), 0);
    check("mid_rst_gen", 32'(generate_next), 0);
    check("mid_rst_underflow", 32'(underflow), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    tick();
    check("mid_rst_first_req", 32'(generate_next), 1);
    repeat (10) tick();
    pop_frame(16'h0AAA);
    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
